// File: rtl/dsi_clk_lane_ctrl.sv
// DSI HS clock-lane sequencer: LP->HS entry, HS->LP exit and a divide-by-DIV byte clock enable.
// Optional clock-lane ULPS entry/wake is built when DSI_CLK_ULPS_EN is defined.
module dsi_clk_lane_ctrl #(
    parameter int CW      = 8,
    parameter int T_LPX   = 4,
    parameter int T_PREP  = 3,
    parameter int T_ZERO  = 16,
    parameter int T_PRE   = 4,
    parameter int T_POST  = 8,
    parameter int T_TRAIL = 4,
    parameter int T_EXIT  = 6
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [1:0] dsi_ctrl0,
    input  logic       hs_req,
    output logic       hs_ack,
    output logic [1:0] clk_lp,
    output logic       clk_hs_en,
    output logic       clk_tgl_en,
    output logic       byte_clk_en,
    output logic [2:0] div_active,
    output logic       busy,
    output logic       cfg_err
`ifdef DSI_CLK_ULPS_EN
    ,
    input  logic       ulps_req,
    output logic       ulps_active
`endif
);

    typedef enum logic [3:0] {
        IDLE, LPX, PREP, ZERO, PRE, RUN, POST, TRAIL, EXIT
`ifdef DSI_CLK_ULPS_EN
        , U_ENT, ULPS, U_WAKE
`endif
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] timer;
    logic [1:0]    sel;
    logic [2:0]    div_cnt;
    logic [4:0]    lane_nxt;

    function automatic logic [2:0] div_of(input logic [1:0] s);
        case (s)
            2'b01:   return 3'd1;
            2'b00:   return 3'd2;
            2'b10:   return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    // Length of each timed state; untimed states report 1 so the timer loads 0.
    function automatic int dur(input state_t s);
        case (s)
            LPX:     return T_LPX;
            PREP:    return T_PREP;
            ZERO:    return T_ZERO;
            PRE:     return T_PRE;
            POST:    return T_POST;
            TRAIL:   return T_TRAIL;
            EXIT:    return T_EXIT;
`ifdef DSI_CLK_ULPS_EN
            U_ENT:   return T_LPX;
            U_WAKE:  return 64;
`endif
            default: return 1;
        endcase
    endfunction

    // {clk_lp[1:0], clk_hs_en, clk_tgl_en, hs_ack}
    function automatic logic [4:0] lane_of(input state_t s);
        case (s)
            LPX:         return 5'b01_0_0_0;
            PREP:        return 5'b00_0_0_0;
            ZERO, TRAIL: return 5'b00_1_0_0;
            PRE, POST:   return 5'b00_1_1_0;
            RUN:         return 5'b00_1_1_1;
`ifdef DSI_CLK_ULPS_EN
            U_ENT:       return 5'b10_0_0_0;
            ULPS:        return 5'b00_0_0_0;
            U_WAKE:      return 5'b10_0_0_0;
`endif
            default:     return 5'b11_0_0_0;
        endcase
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (hs_req) nxt = LPX;
`ifdef DSI_CLK_ULPS_EN
                else if (ulps_req) nxt = U_ENT;
`endif
            end
            LPX:    if (timer == '0) nxt = PREP;
            PREP:   if (timer == '0) nxt = ZERO;
            ZERO:   if (timer == '0) nxt = PRE;
            PRE:    if (timer == '0) nxt = RUN;
            RUN:    if (!hs_req)     nxt = POST;
            POST:   if (timer == '0) nxt = TRAIL;
            TRAIL:  if (timer == '0) nxt = EXIT;
            EXIT:   if (timer == '0) nxt = IDLE;
`ifdef DSI_CLK_ULPS_EN
            U_ENT:  if (timer == '0) nxt = ULPS;
            ULPS:   if (!ulps_req)   nxt = U_WAKE;
            U_WAKE: if (timer == '0) nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    assign lane_nxt    = lane_of(nxt);
    assign byte_clk_en = clk_tgl_en && (div_cnt == div_active - 3'd1);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state                                   <= IDLE;
            timer                                   <= '0;
            sel                                     <= 2'b01;
            div_active                              <= 3'd1;
            div_cnt                                 <= '0;
            cfg_err                                 <= 1'b0;
            busy                                    <= 1'b0;
            {clk_lp, clk_hs_en, clk_tgl_en, hs_ack} <= 5'b11_0_0_0;
`ifdef DSI_CLK_ULPS_EN
            ulps_active                             <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (nxt != state)     timer <= CW'(dur(nxt) - 1);
            else if (timer != '0) timer <= timer - CW'(1);
            if (state == IDLE && nxt == LPX) begin
                sel        <= dsi_ctrl0;
                div_active <= div_of(dsi_ctrl0);
            end
            if (busy && dsi_ctrl0 != sel) cfg_err <= 1'b1;
            // Counter runs only while toggling continues; PRE entry comes from a non-toggling state, so it starts at 0.
            if (clk_tgl_en && lane_nxt[1] && div_cnt != div_active - 3'd1)
                div_cnt <= div_cnt + 3'd1;
            else
                div_cnt <= '0;
            {clk_lp, clk_hs_en, clk_tgl_en, hs_ack} <= lane_nxt;
            busy <= (nxt != IDLE);
`ifdef DSI_CLK_ULPS_EN
            ulps_active <= (nxt == ULPS);
`endif
        end
    end

endmodule

// File: tb/tb_dsi_clk_lane_ctrl.sv
// Bench for dsi_clk_lane_ctrl: directed scenarios plus random hs_req/dsi_ctrl0 traffic,
// checked against a timeline model built from burst start/exit edge offsets.
module tb_dsi_clk_lane_ctrl;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dsi_ctrl0 = 2'b01;
    logic       hs_req = 1'b0;
    logic       hs_ack, clk_hs_en, clk_tgl_en, byte_clk_en, busy, cfg_err;
    logic [1:0] clk_lp;
    logic [2:0] div_active;

    dsi_clk_lane_ctrl dut (
        .pclk(pclk), .rst(rst), .dsi_ctrl0(dsi_ctrl0), .hs_req(hs_req),
        .hs_ack(hs_ack), .clk_lp(clk_lp), .clk_hs_en(clk_hs_en),
        .clk_tgl_en(clk_tgl_en), .byte_clk_en(byte_clk_en),
        .div_active(div_active), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    // Model: a burst accepted at edge k, HS exit begun at edge x (-1 while still entering/running).
    int         n = 0, k = 0, x = -1;
    bit         m_busy = 0, m_err = 0;
    logic [1:0] m_sel = 2'b01;

    function automatic int div_map(input logic [1:0] s);
        case (s)
            2'b01:   return 1;
            2'b00:   return 2;
            2'b10:   return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_sel = 2'b01; x = -1; k = 0;
    endtask

    task automatic model_edge();
        n++;
        if (m_busy && dsi_ctrl0 != m_sel) m_err = 1;
        if (!m_busy) begin
            if (hs_req) begin k = n; x = -1; m_sel = dsi_ctrl0; m_busy = 1; end
        end else begin
            // RUN is first occupied after edge k+27, so edge k+28 is the first to sample hs_req there.
            if (x < 0 && n - k >= 28 && !hs_req) x = n;
            if (x >= 0 && n - x >= 18) m_busy = 0;
        end
    endtask

    function automatic logic [10:0] expv();
        logic [4:0] lane;
        int d, e, dv;
        logic be;
        dv = div_map(m_sel);
        if (!m_busy) lane = 5'b11000;
        else if (x >= 0) begin
            e = n - x;
            lane = (e < 8) ? 5'b00110 : (e < 12) ? 5'b00100 : 5'b11000;
        end else begin
            d = n - k;
            lane = (d < 4) ? 5'b01000 : (d < 7) ? 5'b00000 : (d < 23) ? 5'b00100 :
                   (d < 27) ? 5'b00110 : 5'b00111;
        end
        be = lane[1] && (((n - k - 23) % dv) == dv - 1);
        return {lane, be, 3'(dv), m_busy, m_err};
    endfunction

    function automatic logic [10:0] obs();
        return {clk_lp, clk_hs_en, clk_tgl_en, hs_ack, byte_clk_en, div_active, busy, cfg_err};
    endfunction

    task automatic cyc();
        @(posedge pclk);
        model_edge();
        @(negedge pclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs(), expv()); end
        end
        checks++;
        if (obs() !== 11'b11_0_0_0_0_001_0_0) begin
            errors++; $display("FAIL reset_values got=%b exp=%b", obs(), 11'b11_0_0_0_0_001_0_0);
        end
    endtask

    task automatic test_entry();
        int first_ack = 0, first_byte = 0;
        dsi_ctrl0 = 2'b00;
        hs_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL entry c=%0d got=%b exp=%b", c, obs(), expv()); end
            if (hs_ack && first_ack == 0) first_ack = c;
            if (byte_clk_en && first_byte == 0) first_byte = c;
        end
        checks++;
        if (first_ack != 28) begin errors++; $display("FAIL entry_latency got=%0d exp=28", first_ack); end
        checks++;
        if (first_byte != 25) begin errors++; $display("FAIL first_byte_en got=%0d exp=25", first_byte); end
    endtask

    task automatic test_exit();
        int tgl = 0, hsen = 0, lp11 = 0, ack_seen = 0;
        hs_req = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL exit c=%0d got=%b exp=%b", c, obs(), expv()); end
            tgl += clk_tgl_en;
            hsen += clk_hs_en;
            ack_seen += hs_ack;
            if (clk_lp == 2'b11 && busy) lp11++;
        end
        checks++;
        if (tgl != 8 || hsen != 12 || lp11 != 6 || ack_seen != 0) begin
            errors++; $display("FAIL exit_phases got tgl=%0d hs=%0d lp11=%0d ack=%0d exp 8 12 6 0", tgl, hsen, lp11, ack_seen);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL exit_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_pulse();
        int acks = 0, bytes = 0;
        dsi_ctrl0 = 2'b01;
        cyc();
        hs_req = 1'b1;
        cyc();
        hs_req = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL pulse c=%0d got=%b exp=%b", c, obs(), expv()); end
            acks += hs_ack;
            bytes += byte_clk_en;
            cyc();
        end
        checks++;
        if (acks != 1 || bytes != 13 || busy !== 1'b0) begin
            errors++; $display("FAIL pulse_summary got ack=%0d byte=%0d busy=%b exp 1 13 0", acks, bytes, busy);
        end
    endtask

    task automatic test_cfg_err();
        dsi_ctrl0 = 2'b00;
        hs_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL cfg_pre c=%0d got=%b exp=%b", c, obs(), expv()); end
        end
        dsi_ctrl0 = 2'b11;
        cyc();
        checks++;
        if (cfg_err !== 1'b1 || div_active !== 3'd2) begin
            errors++; $display("FAIL cfg_err_set got err=%b div=%0d exp 1 2", cfg_err, div_active);
        end
        hs_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL cfg_post c=%0d got=%b exp=%b", c, obs(), expv()); end
        end
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || div_active !== 3'd2) begin
            errors++; $display("FAIL cfg_err_sticky got err=%b busy=%b div=%0d exp 1 0 2", cfg_err, busy, div_active);
        end
    endtask

    task automatic test_async_rst();
        dsi_ctrl0 = 2'b10;
        hs_req = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL arst_entry c=%0d got=%b exp=%b", c, obs(), expv()); end
        end
        checks++;
        if (clk_tgl_en !== 1'b1 || hs_ack !== 1'b0) begin
            errors++; $display("FAIL arst_in_pre got tgl=%b ack=%b exp 1 0", clk_tgl_en, hs_ack);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 11'b11_0_0_0_0_001_0_0) begin
            errors++; $display("FAIL arst_immediate got=%b exp=%b", obs(), 11'b11_0_0_0_0_001_0_0);
        end
        hs_req = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        model_reset();
        cyc();
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL arst_release got=%b exp=%b", obs(), expv()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (!m_busy) begin
                if ($urandom_range(0, 3) == 0) dsi_ctrl0 = 2'($urandom_range(0, 3));
                hs_req = ($urandom_range(0, 5) == 0);
            end else begin
                if ($urandom_range(0, 299) == 0) dsi_ctrl0 = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) hs_req = ~hs_req;
            end
            cyc();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL random c=%0d got=%b exp=%b", c, obs(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_pulse();
        test_cfg_err();
        test_async_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
